uart_ctrl: RTL and testbench
============================

# uart_ctrl

Avalon-MM read master that drains received bytes from a JTAG-UART-style slave on interrupt, packs byte pairs into 16-bit instruction words and writes them to sequential addresses of an external instruction memory (tri-port program memory). It sits between the UART peripheral and the processor's program store as a program loader.

## Interface
- ADDRESS_WIDTH, 11, width of instruction-memory write address.
- clock_in  input  1  system clock; all state updates on rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- readdata_in  input  32  slave read data: [31:16] RAVAIL (bytes remaining after this read), [15] RVALID, [7:0] data byte.
- waitrequest_in  input  1  slave stall; read completes on a rising edge where it is 0.
- irq_in  input  1  slave interrupt, level, 1 = data available.
- chipselect_out  output  1  slave select.
- address_out  output  1  slave register select; always 0 (data register).
- read_n_out  output  1  active-low read strobe.
- write_n_out  output  1  active-low write strobe; constant 1.
- memory_wr_out  output  1  one-cycle memory write enable.
- memory_address_out  output  ADDRESS_WIDTH  memory write address.
- instruction_out  output  16  memory write data.

## Operation
- States: IDLE, READ, STORE, DONE.
- IDLE: waits for irq_in=1, then READ. High-byte flag cleared.
- READ: chipselect_out=1, read_n_out=0, address_out=0, held until waitrequest_in=0. On that edge, byte=readdata_in[7:0] accepted. First byte of a pair goes to instruction[15:8]. Second byte goes to instruction[7:0], and the block then enters STORE.
- After each accepted byte, RAVAIL=readdata_in[31:16] is checked. If RAVAIL≠0, stay in READ. If RAVAIL=0, the burst ends.
- Odd byte count at burst end: low byte is padded with 0x00 and the word is stored.
- STORE: memory_wr_out=1 for exactly one cycle, with instruction_out and memory_address_out stable. Next cycle address increments and the block returns to READ, or to DONE if the burst ended.
- DONE: waits for irq_in=0, then IDLE. A level irq never re-triggers the same burst.
- Address persists across bursts. It wraps from 2^ADDRESS_WIDTH−1 to 0.
- write_n_out is always 1; the block never writes the slave.
- Reset values: chipselect_out=0, read_n_out=1, write_n_out=1, address_out=0, memory_wr_out=0, memory_address_out=0, instruction_out=0, state IDLE.
- Reset mid-burst: immediate return to reset values; a partial word is discarded.

## Timing
- irq_in sampled high in IDLE → read strobe asserted the next cycle.
- Bus signals are held throughout waitrequest stalls.
- The read strobe is dropped during the STORE cycle.
- memory_wr_out asserts in the cycle after the second byte's read completes. The memory samples on the falling clock edge within that cycle.
- Minimum throughput: one byte per cycle with waitrequest_in=0, plus one STORE cycle per word.

## Configuration
- UART_CTRL_RVALID_CHECK_EN defined: a completed read with readdata_in[15]=0 carries no byte. Nothing is packed, and the burst ends.
- UART_CTRL_RVALID_CHECK_EN undefined: RVALID is ignored; every completed read supplies a byte.

## Structure
- Package uart_ctrl_pkg holds:
  - the state enum;
  - RAVAIL/RVALID/data field bit positions;
  - the UART data-register address constant (0).
- Optional sub-module uart_ctrl_byte_packer: high/low byte register, pad-on-flush, word-valid pulse.
- The FSM and address counter live in the top.

## Test plan
- Reset, then irq_in=1 with reads returning 0x000300AD, 0x000200E1, 0x00010000, 0x00000000 → writes 0xADE1@0 and 0x0000@1, then DONE.
- irq_in low then high again; reads return 0x0007000F, 0x0006000E, 0x0005000D, 0x0004000C, 0x0003000B, 0x0002000A, 0x00010000, 0x00000000 → writes 0x0F0E@2, 0x0D0C@3, 0x0B0A@4, 0x0000@5.
- Hold waitrequest_in=1 for 5 cycles during READ → read strobe and address stable, no byte taken, no memory_wr_out.
- Three-byte burst 0x00020011, 0x00010022, 0x00000033 → writes 0x1122 then 0x3300.
- irq_in held high after burst end → no further reads until irq_in falls and rises.
- Assert reset_n_in low mid-burst after one byte → outputs return to reset values; the next burst starts at address 0 with a fresh high byte.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and field positions for the UART program loader.
package uart_ctrl_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned RAVAIL_W   = 16;

  // Slave read-data field positions
  localparam int unsigned RAVAIL_LSB = 16;
  localparam int unsigned RVALID_BIT = 15;
  localparam int unsigned DATA_LSB   = 0;

  // UART data register select
  localparam logic UART_DATA_ADDR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_ctrl_byte_packer.sv
// Packs a byte stream into 16-bit words, high byte first; pads the low
// byte with zero when a burst ends on an odd byte.
module uart_ctrl_byte_packer
  import uart_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              flush_i,
  output logic              word_vld_c_o,
  output logic [WORD_W-1:0] word_c_o
);

  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              have_hi_q, have_hi_d;

  // Word completes on the second byte, or on flush with any byte pending
  always_comb begin
    word_vld_c_o = 1'b0;
    word_c_o     = '0;
    hi_d         = hi_q;
    have_hi_d    = have_hi_q;
    if (have_hi_q) begin
      word_vld_c_o = byte_vld_i | flush_i;
      word_c_o     = {hi_q, (byte_vld_i ? byte_i : BYTE_W'(0))};
    end else begin
      word_vld_c_o = byte_vld_i & flush_i;
      word_c_o     = {byte_i, BYTE_W'(0)};
    end
    if (clear_i || word_vld_c_o) begin
      have_hi_d = 1'b0;
    end else if (byte_vld_i) begin
      hi_d      = byte_i;
      have_hi_d = 1'b1;
    end
  end

  // High-byte holding register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q      <= '0;
      have_hi_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      have_hi_q <= have_hi_d;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART program loader: on interrupt, drains the JTAG-UART data register
// over Avalon-MM, packs byte pairs into instruction words and writes them
// to sequential program-memory addresses.
// Optional: `define UART_CTRL_RVALID_CHECK_EN to treat reads with RVALID=0
// as carrying no byte and ending the burst.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 11
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic [DATA_W-1:0]        readdata_in,
  input  logic                     waitrequest_in,
  input  logic                     irq_in,
  output logic                     chipselect_out,
  output logic                     address_out,
  output logic                     read_n_out,
  output logic                     write_n_out,
  output logic                     memory_wr_out,
  output logic [ADDRESS_WIDTH-1:0] memory_address_out,
  output logic [WORD_W-1:0]        instruction_out
);

  state_e                   state_q, state_d;
  logic                     last_q, last_d;
  logic                     cs_q, cs_d;
  logic                     rd_n_q, rd_n_d;
  logic                     mem_wr_q, mem_wr_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]        instr_q, instr_d;

  logic                     read_done_c;
  logic                     ravail_zero_c;
  logic                     byte_vld_c;
  logic                     burst_end_c;
  logic                     word_vld_c;
  logic [WORD_W-1:0]        word_c;

  // Read handshake and burst-end decode
  assign read_done_c   = (state_q == ST_READ) && !waitrequest_in;
  assign ravail_zero_c = (readdata_in[RAVAIL_LSB +: RAVAIL_W] == '0);

`ifdef UART_CTRL_RVALID_CHECK_EN
  logic rvalid_c;
  logic unused_rdata;
  assign rvalid_c     = readdata_in[RVALID_BIT];
  assign byte_vld_c   = read_done_c & rvalid_c;
  assign burst_end_c  = read_done_c & (ravail_zero_c | ~rvalid_c);
  assign unused_rdata = ^readdata_in[RVALID_BIT-1:BYTE_W];
`else
  logic unused_rdata;
  assign byte_vld_c   = read_done_c;
  assign burst_end_c  = read_done_c & ravail_zero_c;
  assign unused_rdata = ^readdata_in[RVALID_BIT:BYTE_W];
`endif

  uart_ctrl_byte_packer u_packer (
    .clk_i        (clock_in),
    .rst_ni       (reset_n_in),
    .clear_i      (state_q == ST_IDLE),
    .byte_vld_i   (byte_vld_c),
    .byte_i       (readdata_in[DATA_LSB +: BYTE_W]),
    .flush_i      (burst_end_c),
    .word_vld_c_o (word_vld_c),
    .word_c_o     (word_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    unique case (state_q)
      ST_IDLE: begin
        last_d = 1'b0;
        if (irq_in) state_d = ST_READ;
      end
      ST_READ: begin
        if (read_done_c) begin
          last_d = burst_end_c;
          if (word_vld_c) begin
            instr_d = word_c;
            state_d = ST_STORE;
          end else if (burst_end_c) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_STORE: begin
        mem_addr_d = mem_addr_q + ADDRESS_WIDTH'(1);
        state_d    = last_q ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        if (!irq_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cs_d     = (state_d == ST_READ);
    rd_n_d   = ~cs_d;
    mem_wr_d = (state_d == ST_STORE);
  end

  // State and output registers
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b0;
      cs_q       <= 1'b0;
      rd_n_q     <= 1'b1;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cs_q       <= cs_d;
      rd_n_q     <= rd_n_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
    end
  end

  assign chipselect_out     = cs_q;
  assign read_n_out         = rd_n_q;
  assign address_out        = UART_DATA_ADDR;
  assign write_n_out        = 1'b1;
  assign memory_wr_out      = mem_wr_q;
  assign memory_address_out = mem_addr_q;
  assign instruction_out    = instr_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for the UART program loader.
module tb_uart_ctrl;

  localparam int unsigned AW = 11;

  logic          clk;
  logic          rst_n;
  logic [31:0]   rdata;
  logic          waitreq;
  logic          irq;
  logic          cs;
  logic          addr_o;
  logic          read_n;
  logic          write_n;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   instr;

  uart_ctrl #(.ADDRESS_WIDTH(AW)) dut (
    .clock_in           (clk),
    .reset_n_in         (rst_n),
    .readdata_in        (rdata),
    .waitrequest_in     (waitreq),
    .irq_in             (irq),
    .chipselect_out     (cs),
    .address_out        (addr_o),
    .read_n_out         (read_n),
    .write_n_out        (write_n),
    .memory_wr_out      (mem_wr),
    .memory_address_out (mem_addr),
    .instruction_out    (instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: response table consumed one entry per completed read
  logic [31:0] resp [0:31];
  int          rd_idx = 0;
  always_comb rdata = resp[rd_idx[4:0]];
  always @(posedge clk) begin
    if (cs && !read_n && !waitreq) rd_idx <= rd_idx + 1;
  end

  // Memory-side capture on the falling edge
  int            ncap = 0;
  logic [AW-1:0] cap_a [0:15];
  logic [15:0]   cap_d [0:15];
  always @(negedge clk) begin
    if (mem_wr === 1'b1 && ncap < 16) begin
      cap_a[ncap] = mem_addr;
      cap_d[ncap] = instr;
      ncap        = ncap + 1;
    end
  end

  logic [AW-1:0] exp_a [0:8] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd0};
  logic [15:0]   exp_d [0:8] = '{16'hADE1, 16'h0000, 16'h0F0E, 16'h0D0C, 16'h0B0A,
                                 16'h0000, 16'h1122, 16'h3300, 16'hAABB};

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cs"},     32'(cs),       32'd0);
    check({tag, "_rd_n"},   32'(read_n),   32'd1);
    check({tag, "_wr_n"},   32'(write_n),  32'd1);
    check({tag, "_addr"},   32'(addr_o),   32'd0);
    check({tag, "_mem_wr"}, 32'(mem_wr),   32'd0);
    check({tag, "_maddr"},  32'(mem_addr), 32'd0);
    check({tag, "_instr"},  32'(instr),    32'd0);
  endtask

  task automatic wait_cap(input int n, input int budget);
    int k = 0;
    while (ncap < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wr_count", 32'(ncap), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) resp[i] = 32'h0;
    resp[0]  = 32'h000300AD; resp[1]  = 32'h000200E1;
    resp[2]  = 32'h00010000; resp[3]  = 32'h00000000;
    resp[4]  = 32'h0007000F; resp[5]  = 32'h0006000E;
    resp[6]  = 32'h0005000D; resp[7]  = 32'h0004000C;
    resp[8]  = 32'h0003000B; resp[9]  = 32'h0002000A;
    resp[10] = 32'h00010000; resp[11] = 32'h00000000;
    resp[12] = 32'h00020011; resp[13] = 32'h00010022;
    resp[14] = 32'h00000033;
    resp[15] = 32'h00050077;
    resp[16] = 32'h000100AA; resp[17] = 32'h000000BB;

    rst_n   = 1'b0;
    irq     = 1'b0;
    waitreq = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cs", 32'(cs), 32'd0);

    // Burst 1: strobe one cycle after irq, then 0xADE1@0, 0x0000@1
    irq = 1'b1;
    @(posedge clk);
    #1;
    check("strobe_cs",   32'(cs),     32'd1);
    check("strobe_rd_n", 32'(read_n), 32'd0);
    check("strobe_addr", 32'(addr_o), 32'd0);
    wait_cap(2, 50);
    // irq held high: no re-trigger
    repeat (10) @(negedge clk);
    check("b1_reads",  32'(rd_idx), 32'd4);
    check("done_cs",   32'(cs),     32'd0);
    check("done_wr_n", 32'(write_n), 32'd1);

    // Burst 2 after irq falls and rises
    irq = 1'b0;
    repeat (2) @(negedge clk);
    irq = 1'b1;
    wait_cap(6, 100);
    repeat (3) @(negedge clk);
    check("b2_reads", 32'(rd_idx), 32'd12);

    // Burst 3 with a 5-cycle waitrequest stall at the start
    irq = 1'b0;
    repeat (2) @(negedge clk);
    waitreq = 1'b1;
    irq     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_cs",     32'(cs),     32'd1);
      check("stall_rd_n",   32'(read_n), 32'd0);
      check("stall_addr",   32'(addr_o), 32'd0);
      check("stall_mem_wr", 32'(mem_wr), 32'd0);
      check("stall_idx",    32'(rd_idx), 32'd12);
    end
    waitreq = 1'b0;
    wait_cap(8, 50);
    repeat (3) @(negedge clk);
    check("b3_reads", 32'(rd_idx), 32'd15);

    // Burst 4: one byte accepted, then reset mid-burst
    irq = 1'b0;
    repeat (2) @(negedge clk);
    waitreq = 1'b1;
    irq     = 1'b1;
    repeat (2) @(negedge clk);
    waitreq = 1'b0;
    @(posedge clk);
    #1;
    waitreq = 1'b1;
    check("b4_idx", 32'(rd_idx), 32'd16);
    @(negedge clk);
    check("b4_cs", 32'(cs), 32'd1);
    check("b4_maddr_pre", 32'(mem_addr), 32'd8);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    irq     = 1'b0;
    waitreq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    irq = 1'b1;
    wait_cap(9, 50);
    repeat (3) @(negedge clk);
    check("b5_reads", 32'(rd_idx), 32'd18);
    check("b5_cs",    32'(cs),     32'd0);

    // Memory write stream
    for (int i = 0; i < 9; i++) begin
      if (i < ncap) begin
        check($sformatf("wr%0d_addr", i), 32'(cap_a[i]), 32'(exp_a[i]));
        check($sformatf("wr%0d_data", i), 32'(cap_d[i]), 32'(exp_d[i]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
